// File: rtl/fetch_decode_ctrl.sv
// +--------------------------------------------------------------------------+
// | fetch_decode_ctrl: fetch/decode/indirect sequencer for the basic computer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_decode_ctrl #(
  parameter int DATA_W      = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ir_in,
  input  logic              mem_ready,
  input  logic              exec_done,
  output logic [2:0]        bus_sel,
  output logic              ld_ar,
  output logic              ld_ir,
  output logic              incr_pc,
  output logic              mem_rd,
  output logic              ld_i,
  output logic [2:0]        opcode,
  output logic              d7,
  output logic              exec_start,
  output logic [2:0]        sc,
  output logic              halted,
  output logic              mem_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T0     = 3'd1,
    S_T1     = 3'd2,
    S_T2     = 3'd3,
    S_T3     = 3'd4,
    S_EXEC   = 3'd5,
    S_HALTED = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_MEM  = 3'd7;
  localparam logic [7:0] CNT_MAX  = 8'hFF;
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] opcode_q, opcode_d;
  logic       d7_q, d7_d;
  logic       exec_first_q, exec_first_d;

  logic       ir_i;
  logic [2:0] ir_op;
  logic       ir_d7;
  logic       timeout;

  assign ir_i    = ir_in[DATA_W-1];
  assign ir_op   = ir_in[DATA_W-2 -: 3];
  assign ir_d7   = (ir_op == 3'd7);
  // The cycle whose increment would reach MEM_TIMEOUT is the last one allowed.
  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      opcode_q     <= 3'd0;
      d7_q         <= 1'b0;
      exec_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opcode_q     <= opcode_d;
      d7_q         <= d7_d;
      exec_first_q <= exec_first_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = 8'd0;
    opcode_d     = opcode_q;
    d7_d         = d7_q;
    exec_first_d = 1'b0;
    bus_sel      = BUS_NONE;
    ld_ar        = 1'b0;
    ld_ir        = 1'b0;
    incr_pc      = 1'b0;
    mem_rd       = 1'b0;
    ld_i         = 1'b0;
    exec_start   = 1'b0;
    halted       = 1'b0;
    mem_err      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_T0;
      end
      S_T0: begin
        bus_sel = BUS_PC;
        ld_ar   = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        bus_sel = BUS_MEM;
        mem_rd  = 1'b1;
        cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        if (mem_ready) begin
          ld_ir   = 1'b1;
          incr_pc = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_T2;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_T2: begin
        ld_i     = 1'b1;
        opcode_d = ir_op;
        d7_d     = ir_d7;
        if (ir_d7 && !ir_i && ir_in[0]) begin
          state_d = S_HALTED;
        end else if (!ir_d7 && ir_i) begin
          state_d = S_T3;
        end else begin
          state_d      = S_EXEC;
          exec_first_d = 1'b1;
        end
      end
      S_T3: begin
        bus_sel = BUS_MEM;
        mem_rd  = 1'b1;
        cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        if (mem_ready) begin
          ld_ar        = 1'b1;
          cnt_d        = 8'd0;
          state_d      = S_EXEC;
          exec_first_d = 1'b1;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_EXEC: begin
        exec_start = exec_first_q;
        if (exec_done) state_d = S_T0;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) state_d = S_T0;
      end
      S_ERR: begin
        mem_err = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign opcode = opcode_q;
  assign d7     = d7_q;
  assign sc     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_decode_ctrl: directed self-checking bench for fetch_decode_ctrl  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_decode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] ir_in;
  logic        mem_ready;
  logic        exec_done;
  logic [2:0]  bus_sel;
  logic        ld_ar, ld_ir, incr_pc, mem_rd, ld_i;
  logic [2:0]  opcode;
  logic        d7, exec_start;
  logic [2:0]  sc;
  logic        halted, mem_err;

  int errors = 0;
  int checks = 0;

  fetch_decode_ctrl #(.DATA_W(16), .MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ir_in      (ir_in),
    .mem_ready  (mem_ready),
    .exec_done  (exec_done),
    .bus_sel    (bus_sel),
    .ld_ar      (ld_ar),
    .ld_ir      (ld_ir),
    .incr_pc    (incr_pc),
    .mem_rd     (mem_rd),
    .ld_i       (ld_i),
    .opcode     (opcode),
    .d7         (d7),
    .exec_start (exec_start),
    .sc         (sc),
    .halted     (halted),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Concatenation of every strobe, so one compare covers "all strobes idle".
  function automatic logic [9:0] strobes();
    return {bus_sel, ld_ar, ld_ir, incr_pc, mem_rd, ld_i, exec_start, mem_err};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ir_in = 16'h2005; mem_ready = 1'b0; exec_done = 1'b0;
    #12;
    checks++; if (sc !== 3'd0 || strobes() !== 10'd0 || halted !== 1'b0 || opcode !== 3'd0 || d7 !== 1'b0) begin errors++; $display("FAIL reset_init: sc=%0d strobes=%h halted=%b opcode=%0d d7=%b, want all 0", sc, strobes(), halted, opcode, d7); end
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++; if (sc !== 3'd2 || mem_rd !== 1'b1) begin errors++; $display("FAIL reset_pre_t1: sc=%0d mem_rd=%b, want 2/1", sc, mem_rd); end
    #2 rst_n = 1'b0; #1;
    checks++; if (sc !== 3'd0 || strobes() !== 10'd0 || halted !== 1'b0) begin errors++; $display("FAIL reset_mid_t1: sc=%0d strobes=%h, want 0/0", sc, strobes()); end
    #3 rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (sc !== 3'd0 || ld_ar !== 1'b0) begin errors++; $display("FAIL reset_stay_idle: sc=%0d ld_ar=%b, want 0/0", sc, ld_ar); end
  endtask

  task automatic test_direct();
    ir_in = 16'h2005;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (sc !== 3'd1 || ld_ar !== 1'b1 || bus_sel !== 3'd2) begin errors++; $display("FAIL dir_t0: sc=%0d ld_ar=%b bus_sel=%0d, want 1/1/2", sc, ld_ar, bus_sel); end
    tick(); mem_ready = 1'b1; #1;
    checks++; if (sc !== 3'd2 || ld_ir !== 1'b1 || incr_pc !== 1'b1 || bus_sel !== 3'd7 || mem_rd !== 1'b1) begin errors++; $display("FAIL dir_t1: sc=%0d ld_ir=%b incr_pc=%b bus_sel=%0d mem_rd=%b, want 2/1/1/7/1", sc, ld_ir, incr_pc, bus_sel, mem_rd); end
    tick(); mem_ready = 1'b0;
    checks++; if (sc !== 3'd3 || ld_i !== 1'b1 || mem_rd !== 1'b0 || exec_start !== 1'b0) begin errors++; $display("FAIL dir_t2: sc=%0d ld_i=%b mem_rd=%b exec_start=%b, want 3/1/0/0", sc, ld_i, mem_rd, exec_start); end
    tick();
    checks++; if (sc !== 3'd5 || exec_start !== 1'b1 || opcode !== 3'd2 || d7 !== 1'b0) begin errors++; $display("FAIL dir_exec: sc=%0d exec_start=%b opcode=%0d d7=%b, want 5/1/2/0", sc, exec_start, opcode, d7); end
    tick();
    checks++; if (sc !== 3'd5 || exec_start !== 1'b0) begin errors++; $display("FAIL dir_exec_wait: sc=%0d exec_start=%b, want 5/0", sc, exec_start); end
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    checks++; if (sc !== 3'd1 || ld_ar !== 1'b1) begin errors++; $display("FAIL dir_return_t0: sc=%0d ld_ar=%b, want 1/1", sc, ld_ar); end
  endtask

  task automatic test_indirect();
    ir_in = 16'hA005;
    tick();
    checks++; if (sc !== 3'd2 || ld_ir !== 1'b0 || mem_rd !== 1'b1) begin errors++; $display("FAIL ind_t1_wait: sc=%0d ld_ir=%b mem_rd=%b, want 2/0/1", sc, ld_ir, mem_rd); end
    tick(); mem_ready = 1'b1; #1;
    checks++; if (ld_ir !== 1'b1 || incr_pc !== 1'b1) begin errors++; $display("FAIL ind_t1_ready: ld_ir=%b incr_pc=%b, want 1/1", ld_ir, incr_pc); end
    tick(); mem_ready = 1'b0;
    checks++; if (sc !== 3'd3 || ld_i !== 1'b1) begin errors++; $display("FAIL ind_t2: sc=%0d ld_i=%b, want 3/1", sc, ld_i); end
    tick();
    checks++; if (sc !== 3'd4 || mem_rd !== 1'b1 || bus_sel !== 3'd7 || ld_ar !== 1'b0 || exec_start !== 1'b0) begin errors++; $display("FAIL ind_t3_wait: sc=%0d mem_rd=%b bus_sel=%0d ld_ar=%b exec_start=%b, want 4/1/7/0/0", sc, mem_rd, bus_sel, ld_ar, exec_start); end
    mem_ready = 1'b1; #1;
    checks++; if (ld_ar !== 1'b1 || bus_sel !== 3'd7 || ld_ir !== 1'b0) begin errors++; $display("FAIL ind_t3_ready: ld_ar=%b bus_sel=%0d ld_ir=%b, want 1/7/0", ld_ar, bus_sel, ld_ir); end
    tick(); mem_ready = 1'b0;
    checks++; if (sc !== 3'd5 || exec_start !== 1'b1 || opcode !== 3'd2 || mem_rd !== 1'b0) begin errors++; $display("FAIL ind_exec: sc=%0d exec_start=%b opcode=%0d mem_rd=%b, want 5/1/2/0", sc, exec_start, opcode, mem_rd); end
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    checks++; if (sc !== 3'd1) begin errors++; $display("FAIL ind_return_t0: sc=%0d, want 1", sc); end
  endtask

  task automatic test_halt();
    ir_in = 16'h7001;
    tick(); mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    checks++; if (sc !== 3'd3 || ld_i !== 1'b1) begin errors++; $display("FAIL hlt_t2: sc=%0d ld_i=%b, want 3/1", sc, ld_i); end
    tick();
    checks++; if (sc !== 3'd6 || halted !== 1'b1 || exec_start !== 1'b0 || d7 !== 1'b1 || opcode !== 3'd7) begin errors++; $display("FAIL hlt_state: sc=%0d halted=%b exec_start=%b d7=%b opcode=%0d, want 6/1/0/1/7", sc, halted, exec_start, d7, opcode); end
    tick();
    checks++; if (sc !== 3'd6 || halted !== 1'b1 || ld_ar !== 1'b0) begin errors++; $display("FAIL hlt_hold: sc=%0d halted=%b ld_ar=%b, want 6/1/0", sc, halted, ld_ar); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (sc !== 3'd1 || ld_ar !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL hlt_resume: sc=%0d ld_ar=%b halted=%b, want 1/1/0", sc, ld_ar, halted); end
  endtask

  task automatic test_ready_at_limit();
    ir_in = 16'h2005;
    tick();
    for (int i = 0; i < 14; i++) tick();
    checks++; if (sc !== 3'd2 || mem_err !== 1'b0) begin errors++; $display("FAIL lim_t1_15th: sc=%0d mem_err=%b, want 2/0", sc, mem_err); end
    mem_ready = 1'b1; #1;
    checks++; if (ld_ir !== 1'b1 || incr_pc !== 1'b1) begin errors++; $display("FAIL lim_ready: ld_ir=%b incr_pc=%b, want 1/1", ld_ir, incr_pc); end
    tick(); mem_ready = 1'b0;
    checks++; if (sc !== 3'd3 || mem_err !== 1'b0) begin errors++; $display("FAIL lim_t2: sc=%0d mem_err=%b, want 3/0", sc, mem_err); end
  endtask

  task automatic test_back_to_back();
    exec_done = 1'b1;
    tick();
    checks++; if (sc !== 3'd5 || exec_start !== 1'b1) begin errors++; $display("FAIL b2b_exec: sc=%0d exec_start=%b, want 5/1", sc, exec_start); end
    tick();
    checks++; if (sc !== 3'd1 || ld_ar !== 1'b1 || exec_start !== 1'b0) begin errors++; $display("FAIL b2b_t0: sc=%0d ld_ar=%b exec_start=%b, want 1/1/0", sc, ld_ar, exec_start); end
    exec_done = 1'b0;
  endtask

  task automatic test_timeout();
    tick();
    for (int i = 0; i < 14; i++) tick();
    checks++; if (sc !== 3'd2 || mem_err !== 1'b0) begin errors++; $display("FAIL to_t1_15th: sc=%0d mem_err=%b, want 2/0", sc, mem_err); end
    tick();
    checks++; if (sc !== 3'd7 || mem_err !== 1'b1 || strobes() !== 10'b0000000001) begin errors++; $display("FAIL to_err: sc=%0d mem_err=%b strobes=%h, want 7/1/001", sc, mem_err, strobes()); end
    mem_ready = 1'b1; start = 1'b1; #1;
    checks++; if (ld_ir !== 1'b0 || incr_pc !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL to_late_ready: ld_ir=%b incr_pc=%b mem_rd=%b, want 0/0/0", ld_ir, incr_pc, mem_rd); end
    tick(); tick();
    checks++; if (sc !== 3'd7 || mem_err !== 1'b1 || ld_ar !== 1'b0) begin errors++; $display("FAIL to_sticky: sc=%0d mem_err=%b ld_ar=%b, want 7/1/0", sc, mem_err, ld_ar); end
    mem_ready = 1'b0; start = 1'b0;
    rst_n = 1'b0; #1;
    checks++; if (sc !== 3'd0 || mem_err !== 1'b0) begin errors++; $display("FAIL to_reset_clear: sc=%0d mem_err=%b, want 0/0", sc, mem_err); end
    #2 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_indirect();
    test_halt();
    test_ready_at_limit();
    test_back_to_back();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
